// File: rtl/wb_stage_mi.sv
// wb_stage_mi: multi-lane MEM->WB register driving RF/HI/LO writes, forwarding and the debug trace port.
// Define WB_TRACE_FIFO_EN to serialise every retiring lane through a trace FIFO; otherwise lane 0 is traced directly.
module wb_stage_mi #(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_i,
  input  logic                  bubble_i,
  input  logic                  flush_i,
  input  logic [LANES-1:0]      in_valid,
  input  logic [32*LANES-1:0]   in_pc,
  input  logic [LANES-1:0]      in_rf_we,
  input  logic [5*LANES-1:0]    in_rf_waddr,
  input  logic [32*LANES-1:0]   in_rf_wdata,
  input  logic                  in_hi_we,
  input  logic                  in_lo_we,
  input  logic [31:0]           in_hi_wdata,
  input  logic [31:0]           in_lo_wdata,
  output logic [LANES-1:0]      rf_we,
  output logic [5*LANES-1:0]    rf_waddr,
  output logic [32*LANES-1:0]   rf_wdata,
  output logic                  hi_we,
  output logic                  lo_we,
  output logic [31:0]           hi_wdata,
  output logic [31:0]           lo_wdata,
  output logic                  trace_stall_req,
  output logic                  trace_overflow,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  logic        r_valid [LANES];
  logic [31:0] r_pc    [LANES];
  logic        r_we    [LANES];
  logic [4:0]  r_waddr [LANES];
  logic [31:0] r_wdata [LANES];
  logic        r_hi_we;
  logic        r_lo_we;
  logic [31:0] r_hi_wdata;
  logic [31:0] r_lo_wdata;

  logic                 w_load;
  logic [LANES-1:0]     w_rf_we;
  logic [32*LANES-1:0]  w_pc_flat;
  logic                 w_unused_pc;

  assign w_load = !flush_i && !bubble_i && !hold_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i || bubble_i) begin
      for (int i = 0; i < LANES; i++) begin
        r_valid[i] <= 1'b0;
        r_pc[i]    <= 32'd0;
        r_we[i]    <= 1'b0;
        r_waddr[i] <= 5'd0;
        r_wdata[i] <= 32'd0;
      end
      r_hi_we    <= 1'b0;
      r_lo_we    <= 1'b0;
      r_hi_wdata <= 32'd0;
      r_lo_wdata <= 32'd0;
    end else if (!hold_i) begin
      for (int i = 0; i < LANES; i++) begin
        r_valid[i] <= in_valid[i];
        r_pc[i]    <= in_pc[32*i +: 32];
        r_we[i]    <= in_rf_we[i];
        r_waddr[i] <= in_rf_waddr[5*i +: 5];
        r_wdata[i] <= in_rf_wdata[32*i +: 32];
      end
      r_hi_we    <= in_hi_we;
      r_lo_we    <= in_lo_we;
      r_hi_wdata <= in_hi_wdata;
      r_lo_wdata <= in_lo_wdata;
    end
  end

  // A younger lane writing the same register wins; older lanes are squashed.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_rf_we[i] = r_valid[i] & r_we[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (r_valid[j] && r_we[j] && (r_waddr[j] == r_waddr[i])) w_rf_we[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign rf_waddr[5*g +: 5]   = r_waddr[g];
    assign rf_wdata[32*g +: 32] = r_wdata[g];
    assign w_pc_flat[32*g +: 32] = r_pc[g];
  end

  assign w_unused_pc = ^w_pc_flat;

  assign rf_we    = w_rf_we;
  assign hi_we    = r_hi_we & r_valid[0];
  assign lo_we    = r_lo_we & r_valid[0];
  assign hi_wdata = r_hi_wdata;
  assign lo_wdata = r_lo_wdata;

`ifdef WB_TRACE_FIFO_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = $clog2(TRACE_DEPTH + 1);

  logic [31:0]      r_tq_pc    [TRACE_DEPTH];
  logic             r_tq_we    [TRACE_DEPTH];
  logic [4:0]       r_tq_waddr [TRACE_DEPTH];
  logic [31:0]      r_tq_wdata [TRACE_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_pop;
  logic             w_empty;
  logic             w_drop;
  logic [CNT_W-1:0] w_space;
  logic [CNT_W-1:0] w_n_enq;
  logic [LANES-1:0] w_enq;
  logic [PTR_W-1:0] w_enq_off [LANES];

  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty;
  assign w_space = CNT_W'(TRACE_DEPTH) - r_count + CNT_W'(w_pop);

  // Valid lanes are packed in lane order; once space runs out the younger lanes are dropped.
  always_comb begin
    w_n_enq = '0;
    w_drop  = 1'b0;
    w_enq   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_enq_off[i] = w_n_enq[PTR_W-1:0];
      if (w_load && in_valid[i]) begin
        if (w_n_enq < w_space) begin
          w_enq[i] = 1'b1;
          w_n_enq  = w_n_enq + 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_enq[i]) begin
          r_tq_pc[r_wptr + w_enq_off[i]]    <= in_pc[32*i +: 32];
          r_tq_we[r_wptr + w_enq_off[i]]    <= in_rf_we[i];
          r_tq_waddr[r_wptr + w_enq_off[i]] <= in_rf_waddr[5*i +: 5];
          r_tq_wdata[r_wptr + w_enq_off[i]] <= in_rf_wdata[32*i +: 32];
        end
      end
      r_wptr  <= r_wptr + w_n_enq[PTR_W-1:0];
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count - CNT_W'(w_pop) + w_n_enq;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign debug_wb_pc       = w_empty ? 32'd0 : r_tq_pc[r_rptr];
  assign debug_wb_rf_wen   = {4{!w_empty && r_tq_we[r_rptr]}};
  assign debug_wb_rf_wnum  = w_empty ? 5'd0 : r_tq_waddr[r_rptr];
  assign debug_wb_rf_wdata = w_empty ? 32'd0 : r_tq_wdata[r_rptr];
  assign trace_stall_req   = (CNT_W'(TRACE_DEPTH) - r_count) < CNT_W'(2*LANES);
  assign trace_overflow    = r_overflow;
`else
  logic [31:0] w_unused_depth;
  logic        w_unused_load;

  assign w_unused_depth    = TRACE_DEPTH;
  assign w_unused_load     = w_load;
  assign debug_wb_pc       = r_pc[0];
  assign debug_wb_rf_wen   = {4{w_rf_we[0]}};
  assign debug_wb_rf_wnum  = r_waddr[0];
  assign debug_wb_rf_wdata = r_wdata[0];
  assign trace_stall_req   = 1'b0;
  assign trace_overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage_mi.sv
// Scoreboard bench for wb_stage_mi (LANES=2, TRACE_DEPTH=8); adapts to WB_TRACE_FIFO_EN.
module tb_wb_stage_mi;
  localparam int LANES = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, hold_i, bubble_i, flush_i;
  logic [LANES-1:0]    in_valid, in_rf_we;
  logic [32*LANES-1:0] in_pc, in_rf_wdata;
  logic [5*LANES-1:0]  in_rf_waddr;
  logic                in_hi_we, in_lo_we;
  logic [31:0]         in_hi_wdata, in_lo_wdata;
  logic [LANES-1:0]    rf_we;
  logic [5*LANES-1:0]  rf_waddr;
  logic [32*LANES-1:0] rf_wdata;
  logic                hi_we, lo_we;
  logic [31:0]         hi_wdata, lo_wdata;
  logic                trace_stall_req, trace_overflow;
  logic [31:0]         debug_wb_pc;
  logic [3:0]          debug_wb_rf_wen;
  logic [4:0]          debug_wb_rf_wnum;
  logic [31:0]         debug_wb_rf_wdata;

  wb_stage_mi #(.LANES(LANES), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .bubble_i(bubble_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_pc(in_pc), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_rf_wdata(in_rf_wdata), .in_hi_we(in_hi_we), .in_lo_we(in_lo_we),
    .in_hi_wdata(in_hi_wdata), .in_lo_wdata(in_lo_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .trace_stall_req(trace_stall_req), .trace_overflow(trace_overflow),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } tr_t;

  typedef struct packed {
    logic [LANES-1:0]    we;
    logic [5*LANES-1:0]  waddr;
    logic [32*LANES-1:0] wdata;
    logic [32:0]         hi;
    logic [32:0]         lo;
  } wb_t;

  wb_t wb_q[$];
  tr_t tr_q[$];

  logic [LANES-1:0]    m_valid, m_we;
  logic [32*LANES-1:0] m_pc, m_wdata;
  logic [5*LANES-1:0]  m_waddr;
  logic                m_hiwe, m_lowe;
  logic [31:0]         m_hid, m_lod;
  logic                m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic wb_t exp_wb();
    wb_t e;
    e.waddr = m_waddr;
    e.wdata = m_wdata;
    for (int i = 0; i < LANES; i++) begin
      e.we[i] = m_valid[i] & m_we[i];
      for (int j = i + 1; j < LANES; j++)
        if (m_valid[j] && m_we[j] && (m_waddr[5*j +: 5] == m_waddr[5*i +: 5])) e.we[i] = 1'b0;
    end
    e.hi = {m_hiwe & m_valid[0], m_hid};
    e.lo = {m_lowe & m_valid[0], m_lod};
    return e;
  endfunction

  task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                          input logic we, input logic [4:0] a, input logic [31:0] d);
    in_valid[i]            = v;
    in_pc[32*i +: 32]      = pc;
    in_rf_we[i]            = we;
    in_rf_waddr[5*i +: 5]  = a;
    in_rf_wdata[32*i +: 32] = d;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < LANES; i++) set_lane(i, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    in_hi_we = 1'b0; in_lo_we = 1'b0; in_hi_wdata = 32'd0; in_lo_wdata = 32'd0;
  endtask

  task automatic cycle();
    wb_t e;
    tr_t t;
    if (rst || flush_i || bubble_i) begin
      m_valid = '0; m_we = '0; m_pc = '0; m_wdata = '0; m_waddr = '0;
      m_hiwe = 1'b0; m_lowe = 1'b0; m_hid = 32'd0; m_lod = 32'd0;
    end else if (!hold_i) begin
      m_valid = in_valid; m_we = in_rf_we; m_pc = in_pc; m_wdata = in_rf_wdata;
      m_waddr = in_rf_waddr; m_hiwe = in_hi_we; m_lowe = in_lo_we;
      m_hid = in_hi_wdata; m_lod = in_lo_wdata;
    end
    wb_q.push_back(exp_wb());
`ifdef WB_TRACE_FIFO_EN
    if (rst) begin
      tr_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (tr_q.size() > 0) void'(tr_q.pop_front());
      if (!flush_i && !bubble_i && !hold_i) begin
        for (int i = 0; i < LANES; i++) begin
          if (in_valid[i]) begin
            t = '{pc: in_pc[32*i +: 32], we: in_rf_we[i], waddr: in_rf_waddr[5*i +: 5],
                  wdata: in_rf_wdata[32*i +: 32]};
            if (tr_q.size() < DEPTH) tr_q.push_back(t);
            else m_ovf = 1'b1;
          end
        end
      end
    end
`endif
    @(posedge clk);
    #1;
    e = wb_q.pop_front();
    chk("rf_we", rf_we, e.we);
    chk("rf_waddr", rf_waddr, e.waddr);
    chk("rf_wdata", rf_wdata, e.wdata);
    chk("hi", {hi_we, hi_wdata}, e.hi);
    chk("lo", {lo_we, lo_wdata}, e.lo);
`ifdef WB_TRACE_FIFO_EN
    if (tr_q.size() == 0) begin
      chk("dbg_pc_empty", debug_wb_pc, 32'd0);
      chk("dbg_wen_empty", debug_wb_rf_wen, 4'd0);
      chk("dbg_wnum_empty", debug_wb_rf_wnum, 5'd0);
      chk("dbg_wdata_empty", debug_wb_rf_wdata, 32'd0);
    end else begin
      t = tr_q[0];
      chk("dbg_pc", debug_wb_pc, t.pc);
      chk("dbg_wen", debug_wb_rf_wen, {4{t.we}});
      chk("dbg_wnum", debug_wb_rf_wnum, t.waddr);
      chk("dbg_wdata", debug_wb_rf_wdata, t.wdata);
    end
    chk("stall_req", trace_stall_req, (DEPTH - tr_q.size()) < 2*LANES);
    chk("overflow", trace_overflow, m_ovf);
`else
    chk("dbg_pc", debug_wb_pc, m_pc[31:0]);
    chk("dbg_wen", debug_wb_rf_wen, {4{e.we[0]}});
    chk("dbg_wnum", debug_wb_rf_wnum, m_waddr[4:0]);
    chk("dbg_wdata", debug_wb_rf_wdata, m_wdata[31:0]);
    chk("dbg_not_lane1", (debug_wb_pc == m_pc[63:32]) && m_valid[1] && (m_pc[63:32] != m_pc[31:0]), 1'b0);
    chk("stall_req", trace_stall_req, 1'b0);
    chk("overflow", trace_overflow, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ovf = 1'b0;
    rst = 1'b1; hold_i = 1'b0; bubble_i = 1'b0; flush_i = 1'b0;
    in_valid = '0; in_pc = '0; in_rf_we = '0; in_rf_waddr = '0; in_rf_wdata = '0;
    idle_inputs();
    cycle(); cycle();
    chk("reset_rf_we", rf_we, 2'b00);
    chk("reset_dbg_wen", debug_wb_rf_wen, 4'd0);
    rst = 1'b0;

    // dual retire
    set_lane(0, 1'b1, 32'hBFC0_0000, 1'b1, 5'd3, 32'h11);
    set_lane(1, 1'b1, 32'hBFC0_0004, 1'b1, 5'd4, 32'h22);
    in_hi_we = 1'b1; in_hi_wdata = 32'hDEAD_0001;
    cycle();
    chk("dual_we", rf_we, 2'b11);
    chk("dual_pc0", debug_wb_pc, 32'hBFC0_0000);
    chk("dual_hi_we", hi_we, 1'b1);
    idle_inputs();
    cycle();
`ifdef WB_TRACE_FIFO_EN
    chk("dual_pc1", debug_wb_pc, 32'hBFC0_0004);
    chk("dual_wnum1", debug_wb_rf_wnum, 5'd4);
`endif

    // hold for 3 cycles with different inputs presented
    set_lane(0, 1'b1, 32'h0000_0100, 1'b1, 5'd6, 32'h66);
    set_lane(1, 1'b1, 32'h0000_0104, 1'b1, 5'd7, 32'h77);
    in_lo_we = 1'b1; in_lo_wdata = 32'h1234_5678;
    cycle();
    set_lane(0, 1'b1, 32'h0000_0200, 1'b1, 5'd8, 32'h88);
    set_lane(1, 1'b1, 32'h0000_0204, 1'b0, 5'd9, 32'h99);
    hold_i = 1'b1;
    repeat (3) cycle();
    chk("hold_we", rf_we, 2'b11);
    chk("hold_wdata", rf_wdata, {32'h77, 32'h66});
    hold_i = 1'b0;

    bubble_i = 1'b1;
    cycle();
    chk("bubble_we", rf_we, 2'b00);
    bubble_i = 1'b0;

    flush_i = 1'b1;
    set_lane(0, 1'b1, 32'h0000_0300, 1'b1, 5'd10, 32'hAA);
    set_lane(1, 1'b1, 32'h0000_0304, 1'b1, 5'd11, 32'hBB);
    cycle();
    chk("flush_we", rf_we, 2'b00);
    flush_i = 1'b0;

    // same-address conflict
    idle_inputs();
    set_lane(0, 1'b1, 32'h0000_0400, 1'b1, 5'd5, 32'hA);
    set_lane(1, 1'b1, 32'h0000_0404, 1'b1, 5'd5, 32'hB);
    cycle();
    chk("conf_we", rf_we, 2'b10);
    chk("conf_data", rf_wdata[63:32], 32'hB);

    // address 0 and a non-writing lane
    set_lane(0, 1'b1, 32'h0000_0500, 1'b1, 5'd0, 32'h55);
    set_lane(1, 1'b1, 32'h0000_0504, 1'b0, 5'd12, 32'hCC);
    cycle();
    chk("addr0_we", rf_we, 2'b01);
    idle_inputs();
    repeat (6) cycle();

    // reset with register and trace populated
    set_lane(0, 1'b1, 32'h0000_0600, 1'b1, 5'd13, 32'hD0);
    set_lane(1, 1'b1, 32'h0000_0604, 1'b1, 5'd14, 32'hD4);
    cycle(); cycle();
    idle_inputs();
    rst = 1'b1;
    cycle();
    chk("rst_we", rf_we, 2'b00);
    chk("rst_dbg_wen", debug_wb_rf_wen, 4'd0);
    chk("rst_ovf", trace_overflow, 1'b0);
    rst = 1'b0;

    // back-to-back dual retire, ignoring stall request
    for (int k = 0; k < 11; k++) begin
      set_lane(0, 1'b1, 32'h0000_2000 + 32'(8*k), 1'b1, 5'(16 + k), 32'h1000 + 32'(k));
      set_lane(1, 1'b1, 32'h0000_2004 + 32'(8*k), 1'b1, 5'(1 + k), 32'h2000 + 32'(k));
      cycle();
`ifdef WB_TRACE_FIFO_EN
      if (k == 3) chk("stall_at5", trace_stall_req, 1'b1);
      if (k == 2) chk("nostall_at4", trace_stall_req, 1'b0);
`endif
    end
`ifdef WB_TRACE_FIFO_EN
    chk("ovf_set", trace_overflow, 1'b1);
`endif
    idle_inputs();
    repeat (12) cycle();
`ifdef WB_TRACE_FIFO_EN
    chk("ovf_sticky", trace_overflow, 1'b1);
`endif
    rst = 1'b1;
    cycle();
    chk("final_rst_ovf", trace_overflow, 1'b0);
    rst = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
